// File: rtl/circuit_5_pkg.sv
`default_nettype none
// ============================================================================
// Module      : circuit_5_pkg
// Description : Shared widths and word types for the circuit_5 datapath.
//               IN_W  - operand / internal datapath width (signed)
//               OUT_W - result width (low bits of the internal results)
// Revision    : 1.0 - initial release
// ============================================================================
package circuit_5_pkg;

  localparam int IN_W  = 64;
  localparam int OUT_W = 32;

  typedef logic signed [IN_W-1:0]  word_t;
  typedef logic signed [OUT_W-1:0] out_t;

endpackage : circuit_5_pkg
`default_nettype wire

// File: rtl/circuit_5_if.sv
`default_nettype none
// ============================================================================
// Module      : circuit_5_if
// Description : Operand / result bundle for circuit_5.
//               a, b, c - signed IN_W operands (driven by the master)
//               x, z    - signed OUT_W results (driven by the slave)
//               master  : producer of operands, consumer of results
//               slave   : the datapath itself
// Revision    : 1.0 - initial release
// ============================================================================
interface circuit_5_if;
  import circuit_5_pkg::*;

  word_t a;
  word_t b;
  word_t c;
  out_t  x;
  out_t  z;

  modport master (
    output a,
    output b,
    output c,
    input  x,
    input  z
  );

  modport slave (
    input  a,
    input  b,
    input  c,
    output x,
    output z
  );

endinterface : circuit_5_if
`default_nettype wire

// File: rtl/circuit_5_dp_reg.sv
`default_nettype none
// ============================================================================
// Module      : dp_reg
// Description : Width-parameterised register, asynchronous active-low reset
//               to zero, captures every rising clock edge.
//               clk     - rising-edge clock
//               rst_n   - asynchronous reset, 0 = asserted
//               data_d  - next value
//               data_q  - registered value
// Revision    : 1.0 - initial release
// ============================================================================
module dp_reg #(
  parameter int WIDTH = 64
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] data_d,
  output logic      [WIDTH-1:0] data_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

endmodule : dp_reg
`default_nettype wire

// File: rtl/circuit_5.sv
`default_nettype none
// ============================================================================
// Module      : circuit_5
// Description : Single-stage signed datapath.
//               d = a+b, e = a+c, f = a-b; g = (d<e) ? d : e;
//               h = (d==e) ? g : f. g and h are registered; the outputs are
//               the registered values shifted by the *current* comparison
//               flags and truncated to OUT_W bits:
//                 x = (hreg << dLTe)[OUT_W-1:0]
//                 z = (greg >>> dEQe)[OUT_W-1:0]
//               Clk - rising-edge clock
//               Rst - asynchronous reset, 0 = asserted (clears registers)
//               bus - operands a/b/c in, results x/z out
// Revision    : 1.0 - initial release
// ============================================================================
module circuit_5
  import circuit_5_pkg::*;
(
  input  wire logic   Clk,
  input  wire logic   Rst,
  circuit_5_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Front-end arithmetic, compare and select (all wrap modulo 2^IN_W)
  // --------------------------------------------------------------------------
  word_t d_sum;
  word_t e_sum;
  word_t f_diff;
  word_t g_sel;
  word_t h_sel;
  logic  d_eq_e;
  logic  d_lt_e;

  always_comb begin
    d_sum  = bus.a + bus.b;
    e_sum  = bus.a + bus.c;
    f_diff = bus.a - bus.b;
    d_eq_e = (d_sum == e_sum);
    d_lt_e = (d_sum <  e_sum);   // both operands signed -> signed compare
    g_sel  = d_lt_e ? d_sum : e_sum;
    h_sel  = d_eq_e ? g_sel : f_diff;
  end

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic [IN_W-1:0] greg_d;
  logic [IN_W-1:0] hreg_d;
  logic [IN_W-1:0] greg_raw_q;
  logic [IN_W-1:0] hreg_raw_q;
  word_t           greg_q;
  word_t           hreg_q;

  assign greg_d = g_sel;
  assign hreg_d = h_sel;

  dp_reg #(
    .WIDTH (IN_W)
  ) u_greg (
    .clk    (Clk),
    .rst_n  (Rst),
    .data_d (greg_d),
    .data_q (greg_raw_q)
  );

  dp_reg #(
    .WIDTH (IN_W)
  ) u_hreg (
    .clk    (Clk),
    .rst_n  (Rst),
    .data_d (hreg_d),
    .data_q (hreg_raw_q)
  );

  // Re-type as signed so the right shift below is arithmetic.
  assign greg_q = word_t'(greg_raw_q);
  assign hreg_q = word_t'(hreg_raw_q);

  // --------------------------------------------------------------------------
  // Output shifts. The shift amounts come from the live (unregistered)
  // flags, so a new operand set changes the shift before its values are
  // captured; this skew is part of the intended behaviour.
  // --------------------------------------------------------------------------
  word_t xrin;
  word_t zrin;

  always_comb begin
    xrin = hreg_q <<  d_lt_e;
    zrin = greg_q >>> d_eq_e;
  end

  assign bus.x = xrin[OUT_W-1:0];
  assign bus.z = zrin[OUT_W-1:0];

  // Upper halves of the shifted results are discarded by truncation.
  logic unused_hi;
  assign unused_hi = ^{xrin[IN_W-1:OUT_W], zrin[IN_W-1:OUT_W]};

endmodule : circuit_5
`default_nettype wire

// File: tb/tb_circuit_5.sv
`default_nettype none
// ============================================================================
// Module      : tb_circuit_5
// Description : Directed self-checking bench for circuit_5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_circuit_5;
  import circuit_5_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  circuit_5_if bus ();

  circuit_5 dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input word_t a, input word_t b, input word_t c);
    bus.a = a;
    bus.b = b;
    bus.c = c;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(64'sd15, 64'sd27, 64'sd33);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.x !== 32'sd0) begin
      errors++;
      $display("FAIL reset_x got %0d want 0", bus.x);
    end
    checks++;
    if (bus.z !== 32'sd0) begin
      errors++;
      $display("FAIL reset_z got %0d want 0", bus.z);
    end
  endtask

  task automatic test_nominal;
    @(negedge clk);
    rst = 1'b1;
    drive(64'sd15, 64'sd27, 64'sd33);
    @(posedge clk);
    #1;
    checks++;
    if (bus.z !== 32'sd42) begin
      errors++;
      $display("FAIL nominal_z got %0d want 42", bus.z);
    end
    checks++;
    if (bus.x !== -32'sd24) begin
      errors++;
      $display("FAIL nominal_x got %0d want -24", bus.x);
    end
  endtask

  task automatic test_async_reset;
    // Outputs are nonzero here; assert reset between edges.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.x !== 32'sd0) begin
      errors++;
      $display("FAIL async_reset_x got %0d want 0", bus.x);
    end
    checks++;
    if (bus.z !== 32'sd0) begin
      errors++;
      $display("FAIL async_reset_z got %0d want 0", bus.z);
    end
    // Release mid-cycle; capture resumes on the next rising edge.
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.x !== 32'sd0) begin
      errors++;
      $display("FAIL release_before_edge_x got %0d want 0", bus.x);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.z !== 32'sd42 || bus.x !== -32'sd24) begin
      errors++;
      $display("FAIL resume z/x got %0d/%0d want 42/-24", bus.z, bus.x);
    end
  endtask

  task automatic test_unregistered_flags;
    // Registers hold g=42, h=-12 from a=15,b=27,c=33.
    @(negedge clk);
    drive(64'sd15, 64'sd27, 64'sd33);
    @(posedge clk);
    #1;
    @(negedge clk);
    drive(64'sd10, 64'sd5, 64'sd5);
    #1;
    checks++;
    if (bus.x !== -32'sd12) begin
      errors++;
      $display("FAIL skew_x got %0d want -12", bus.x);
    end
    checks++;
    if (bus.z !== 32'sd21) begin
      errors++;
      $display("FAIL skew_z got %0d want 21", bus.z);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.x !== 32'sd15) begin
      errors++;
      $display("FAIL skew_after_edge_x got %0d want 15", bus.x);
    end
    checks++;
    if (bus.z !== 32'sd7) begin
      errors++;
      $display("FAIL skew_after_edge_z got %0d want 7", bus.z);
    end
  endtask

  // One new operand set per cycle: equal, negatives, truncation, nominal.
  task automatic test_back_to_back;
    word_t va [4];
    word_t vb [4];
    word_t vc [4];
    out_t  ex [4];
    out_t  ez [4];
    string nm [4];
    va[0] = 64'sd10;        vb[0] = 64'sd5;  vc[0] = 64'sd5;
    ex[0] = 32'sd15;        ez[0] = 32'sd7;  nm[0] = "equal";
    va[1] = -64'sd100;      vb[1] = 64'sd50; vc[1] = 64'sd20;
    ex[1] = -32'sd150;      ez[1] = -32'sd80; nm[1] = "negative";
    va[2] = 64'sh1_0000_0000; vb[2] = 64'sd5; vc[2] = 64'sd7;
    ex[2] = 32'shFFFF_FFF6; ez[2] = 32'sd5;  nm[2] = "truncate";
    va[3] = 64'sd15;        vb[3] = 64'sd27; vc[3] = 64'sd33;
    ex[3] = -32'sd24;       ez[3] = 32'sd42; nm[3] = "nominal_again";
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(va[i], vb[i], vc[i]);
      @(posedge clk);
      #1;
      checks++;
      if (bus.x !== ex[i]) begin
        errors++;
        $display("FAIL b2b_%s_x got %0d want %0d", nm[i], bus.x, ex[i]);
      end
      checks++;
      if (bus.z !== ez[i]) begin
        errors++;
        $display("FAIL b2b_%s_z got %0d want %0d", nm[i], bus.z, ez[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    drive('0, '0, '0);
    test_reset();
    test_nominal();
    test_async_reset();
    test_unregistered_flags();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_circuit_5
`default_nettype wire

// File: doc/circuit_5.md
Name: circuit_5

Overview:
- Synthesized dataflow block (HLS-style datapath) that takes three signed 64-bit operands and produces two signed 32-bit results.
- Computes sums and differences, compares them, selects values by mux, registers the two selected values, then applies flag-controlled shifts and truncates to 32 bits.
- Sits as a leaf datapath; one pipeline register stage, no handshake.

Parameters:
- IN_W, 64, operand and internal datapath width (signed two's complement).
- OUT_W, 32, output width; outputs are the low OUT_W bits of the internal results.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- a  input  64  signed operand.
- b  input  64  signed operand.
- c  input  64  signed operand.
- z  output  32  signed result, low 32 bits of zrin.
- x  output  32  signed result, low 32 bits of xrin.

Behaviour:
- Combinational, all signed IN_W, wrap-around modulo 2^64 with no overflow detection:
  - d = a + b
  - e = a + c
  - f = a - b
  - dEQe = (d == e), 1 bit
  - dLTe = (d < e), 1 bit, signed compare
  - g = dLTe ? d : e
  - h = dEQe ? g : f
- Registers, IN_W each, async active-low reset to 0:
  - greg <= g on each rising Clk edge while Rst = 1.
  - hreg <= h on each rising Clk edge while Rst = 1.
- Output path, combinational from the registers plus the current-cycle flags:
  - xrin = hreg << dLTe (logical left shift by 0 or 1).
  - zrin = greg >>> dEQe (arithmetic right shift by 0 or 1; sign preserved).
  - x = xrin[31:0]; z = zrin[31:0]. No saturation.
- Flags are not registered. If inputs change after a capture edge, the shift amount follows the new inputs while the shifted value is the old registered one. This is intentional and must be reproduced.
- Reset:
  - While Rst = 0, greg = hreg = 0 immediately, without waiting for a clock edge.
  - Therefore x = 0 and z = 0 regardless of the flags.
  - Deasserting reset mid-operation resumes capture on the next rising edge.
- Latency: with inputs held stable, x and z are valid after the first rising Clk edge following reset release. Throughput is one new input set per cycle.
- No enables, no valid/ready, no X propagation from reset.

Decomposition:
- Shared package holds IN_W = 64 and OUT_W = 32 constants, plus a signed IN_W word typedef.
- One natural sub-module: dp_reg. It is a parameterized width register with async active-low reset to 0, instantiated twice (greg, hreg).
- Adders, comparators, muxes and shifters stay inline in circuit_5.

Test Plan:
- Reset: hold Rst = 0 with a = 15, b = 27, c = 33 and toggle Clk -> x = 0, z = 0. Then drive Rst = 0 asynchronously mid-cycle after outputs are nonzero -> x and z become 0 without a clock edge.
- Nominal: a = 15, b = 27, c = 33 (d = 42, e = 48, f = -12, dLTe = 1, dEQe = 0), release reset, one edge -> z = 42, x = -24.
- Equal case: a = 10, b = 5, c = 5 (d = e = 15, dEQe = 1, dLTe = 0) -> after one edge, x = 15, z = 7.
- Greater case, negatives: a = -100, b = 50, c = 20 (d = -50, e = -80, f = -150) -> x = -150, z = -80.
- Truncation: a = 2^32, b = 5, c = 7 (dLTe = 1, g = d, h = f = 2^32 - 5) -> x = -10 (0xFFFFFFF6), z = 5.
- Unregistered flags: capture a = 15, b = 27, c = 33, then change to a = 10, b = 5, c = 5 before the next edge -> combinationally x = -12 and z = 21 (old registers, new shifts). After the next edge -> x = 15, z = 7.
